axi_vip_slave_mem: RTL and testbench



---
 rtl/axi_vip_slave_mem.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_axi_vip_slave_mem.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_vip_slave_mem.sv
// axi_vip_slave_mem: behavioural AXI4 slave memory used as off-chip DDR.
// Ports: aclk, areset (sync, active-high); AW/W/B write channels and
//   AR/R read channels, one burst outstanding per direction.
// Storage: mem_byte0..mem_byte3, byte k of word i lives in mem_byteK[i].
module axi_vip_slave_mem #(
    parameter int ID                = 0,
    parameter int MEM_SIZE          = 2**25,
    parameter int AXI_AXID_WIDTH    = 6,
    parameter int AXI_AXADDR_WIDTH  = 32,
    parameter int AXI_AXLEN_WIDTH   = 8,
    parameter int AXI_AXSIZE_WIDTH  = 3,
    parameter int AXI_AXBURST_WIDTH = 2,
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int AXI_RESP_WIDTH    = 2
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [AXI_AXID_WIDTH-1:0]    s_awid,
    input  logic [AXI_AXADDR_WIDTH-1:0]  s_awaddr,
    input  logic [AXI_AXLEN_WIDTH-1:0]   s_awlen,
    input  logic [AXI_AXSIZE_WIDTH-1:0]  s_awsize,
    input  logic [AXI_AXBURST_WIDTH-1:0] s_awburst,
    input  logic                         s_awvalid,
    output logic                         s_awready,
    input  logic [31:0]                  s_wdata,
    input  logic [3:0]                   s_wstrb,
    input  logic                         s_wlast,
    input  logic                         s_wvalid,
    output logic                         s_wready,
    output logic [AXI_AXID_WIDTH-1:0]    s_bid,
    output logic [AXI_RESP_WIDTH-1:0]    s_bresp,
    output logic                         s_bvalid,
    input  logic                         s_bready,
    input  logic [AXI_AXID_WIDTH-1:0]    s_arid,
    input  logic [AXI_AXADDR_WIDTH-1:0]  s_araddr,
    input  logic [AXI_AXLEN_WIDTH-1:0]   s_arlen,
    input  logic [AXI_AXSIZE_WIDTH-1:0]  s_arsize,
    input  logic [AXI_AXBURST_WIDTH-1:0] s_arburst,
    input  logic                         s_arvalid,
    output logic                         s_arready,
    output logic [AXI_AXID_WIDTH-1:0]    s_rid,
    output logic [31:0]                  s_rdata,
    output logic [AXI_RESP_WIDTH-1:0]    s_rresp,
    output logic                         s_rlast,
    output logic                         s_rvalid,
    input  logic                         s_rready
);
    localparam int IW  = $clog2(MEM_SIZE);
    localparam int AW  = AXI_AXADDR_WIDTH;
    localparam int LW  = AXI_AXLEN_WIDTH;
    localparam int SW  = AXI_AXSIZE_WIDTH;
    localparam int BW  = AXI_AXBURST_WIDTH;
    localparam int DW  = AXI_AXID_WIDTH;
    localparam int RW  = AXI_RESP_WIDTH;

    if (ID < 0 || AXI_DATA_WIDTH != 32 || (MEM_SIZE & (MEM_SIZE - 1)) != 0)
    begin : g_cfg_err
        $error("axi_vip_slave_mem %0d: unsupported configuration", ID);
    end

    logic [7:0] mem_byte0 [MEM_SIZE];
    logic [7:0] mem_byte1 [MEM_SIZE];
    logic [7:0] mem_byte2 [MEM_SIZE];
    logic [7:0] mem_byte3 [MEM_SIZE];

    // WRAP only for legal wrap lengths; otherwise the burst walks as INCR.
    function automatic logic [AW-1:0] next_addr(
        input logic [AW-1:0] addr,
        input logic [LW-1:0] len,
        input logic [SW-1:0] size,
        input logic [BW-1:0] burst
    );
        logic [AW-1:0] bytes;
        logic [AW-1:0] wmask;
        logic          wrap_ok;
        bytes   = AW'(1) << size;
        wmask   = ((AW'(len) + AW'(1)) << size) - AW'(1);
        wrap_ok = (len == LW'(1)) || (len == LW'(3)) ||
                  (len == LW'(7)) || (len == LW'(15));
        if (burst == BW'(0))
            next_addr = addr;
        else if (burst == BW'(2) && wrap_ok)
            next_addr = (addr & ~wmask) | ((addr + bytes) & wmask);
        else
            next_addr = (addr & ~(bytes - AW'(1))) + bytes;
    endfunction

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // write channel state
    w_state_e      w_state_q, w_state_d;
    logic          awready_q, awready_d;
    logic          wready_q,  wready_d;
    logic          bvalid_q,  bvalid_d;
    logic [RW-1:0] bresp_q,   bresp_d;
    logic [DW-1:0] bid_q,     bid_d;
    logic [DW-1:0] wid_q,     wid_d;
    logic [AW-1:0] waddr_q,   waddr_d;
    logic [LW-1:0] wlen_q,    wlen_d;
    logic [SW-1:0] wsize_q,   wsize_d;
    logic [BW-1:0] wburst_q,  wburst_d;
    logic [LW-1:0] wcnt_q,    wcnt_d;
    logic          werr_q,    werr_d;

    // read channel state
    r_state_e      r_state_q, r_state_d;
    logic          arready_q, arready_d;
    logic          rvalid_q,  rvalid_d;
    logic          rlast_q,   rlast_d;
    logic [31:0]   rdata_q,   rdata_d;
    logic [DW-1:0] rid_q,     rid_d;
    logic [AW-1:0] raddr_q,   raddr_d;
    logic [LW-1:0] rlen_q,    rlen_d;
    logic [SW-1:0] rsize_q,   rsize_d;
    logic [BW-1:0] rburst_q,  rburst_d;
    logic [LW-1:0] rcnt_q,    rcnt_d;

    logic          w_fire;
    logic          w_final;
    logic [IW-1:0] w_idx;
    logic [AW-1:0] r_next;
    logic [IW-1:0] ar_idx;
    logic [IW-1:0] rn_idx;
    logic [31:0]   ar_word;
    logic [31:0]   rn_word;

    assign w_fire  = wready_q & s_wvalid;
    assign w_final = (wcnt_q == wlen_q);
    assign w_idx   = waddr_q[2 +: IW];

    // Read words are taken from the array before the edge, so a write
    // committed on the same edge is not seen by the beat launched there.
    assign r_next  = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
    assign ar_idx  = s_araddr[2 +: IW];
    assign rn_idx  = r_next[2 +: IW];
    assign ar_word = {mem_byte3[ar_idx], mem_byte2[ar_idx],
                      mem_byte1[ar_idx], mem_byte0[ar_idx]};
    assign rn_word = {mem_byte3[rn_idx], mem_byte2[rn_idx],
                      mem_byte1[rn_idx], mem_byte0[rn_idx]};

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        wid_d     = wid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        unique case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (s_awvalid && awready_q) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    wid_d     = s_awid;
                    waddr_d   = s_awaddr;
                    wlen_d    = s_awlen;
                    wsize_d   = s_awsize;
                    wburst_d  = s_awburst;
                    wcnt_d    = '0;
                    werr_d    = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_fire) begin
                    waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                    wcnt_d  = wcnt_q + LW'(1);
                    // awlen sets the length; a misplaced wlast only flags SLVERR
                    werr_d  = werr_q | (s_wlast != w_final);
                    if (w_final) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = werr_d ? RW'(2) : RW'(0);
                        bid_d     = wid_q;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_arvalid && arready_q) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rid_d     = s_arid;
                    raddr_d   = s_araddr;
                    rlen_d    = s_arlen;
                    rsize_d   = s_arsize;
                    rburst_d  = s_arburst;
                    rcnt_d    = '0;
                    rdata_d   = ar_word;
                    rlast_d   = (s_arlen == '0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        raddr_d = r_next;
                        rdata_d = rn_word;
                        rcnt_d  = rcnt_q + LW'(1);
                        rlast_d = (rcnt_d == rlen_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            bid_q     <= '0;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
        end
    end

    // Memory survives reset; a beat on the reset edge is dropped.
    always_ff @(posedge aclk) begin
        if (w_fire && !areset) begin
            if (s_wstrb[0]) mem_byte0[w_idx] <= s_wdata[7:0];
            if (s_wstrb[1]) mem_byte1[w_idx] <= s_wdata[15:8];
            if (s_wstrb[2]) mem_byte2[w_idx] <= s_wdata[23:16];
            if (s_wstrb[3]) mem_byte3[w_idx] <= s_wdata[31:24];
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_bid     = bid_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rlast   = rlast_q;
    assign s_rdata   = rdata_q;
    assign s_rid     = rid_q;
    assign s_rresp   = '0;

endmodule

// File: tb/tb_axi_vip_slave_mem.sv
// tb_axi_vip_slave_mem: randomized self-checking bench for the AXI memory.
// Expected data comes from a word-array model with its own burst walker.
module tb_axi_vip_slave_mem;
    localparam int MEMW = 1024;

    logic        aclk = 1'b0;
    logic        areset;
    logic [5:0]  s_awid;
    logic [31:0] s_awaddr;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic        s_awvalid, s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast, s_wvalid, s_wready;
    logic [5:0]  s_bid;
    logic [1:0]  s_bresp;
    logic        s_bvalid, s_bready;
    logic [5:0]  s_arid;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_arvalid, s_arready;
    logic [5:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast, s_rvalid, s_rready;

    always #5 aclk = ~aclk;

    axi_vip_slave_mem #(.ID(0), .MEM_SIZE(MEMW)) dut (
        .aclk(aclk), .areset(areset),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
        .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [MEMW];

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic        wl [16];
    logic [1:0]  w_bresp;
    logic [5:0]  w_bid;
    int          w_tmg_err;

    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [5:0]  rd_id   [16];
    logic [1:0]  rd_resp [16];
    int          r_tmg_err;
    int          r_unstable;

    // Address of beat i, from the burst rules as closed-form arithmetic.
    function automatic logic [31:0] beat_addr(logic [31:0] start, int len,
                                              int size, int burst, int i);
        logic [31:0] bytes, wlen, base;
        bytes = 32'(1) << size;
        if (burst == 0) return start;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            wlen = 32'(len + 1) * bytes;
            base = start - (start % wlen);
            return base + ((start - base + 32'(i) * bytes) % wlen);
        end
        if (i == 0) return start;
        return start - (start % bytes) + 32'(i) * bytes;
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'((a >> 2) % MEMW);
    endfunction

    function automatic logic [31:0] peek(int idx);
        return {dut.mem_byte3[idx], dut.mem_byte2[idx],
                dut.mem_byte1[idx], dut.mem_byte0[idx]};
    endfunction

    task automatic poke(int idx, logic [31:0] v);
        dut.mem_byte0[idx] = v[7:0];
        dut.mem_byte1[idx] = v[15:8];
        dut.mem_byte2[idx] = v[23:16];
        dut.mem_byte3[idx] = v[31:24];
        ref_mem[idx] = v;
    endtask

    task automatic model_write(logic [31:0] addr, int len, int size, int burst,
                               int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            int idx;
            idx = widx(beat_addr(addr, len, size, burst, i));
            for (int k = 0; k < 4; k++)
                if (ws[i][k]) ref_mem[idx][8*k +: 8] = wd[i][8*k +: 8];
        end
    endtask

    function automatic logic [1:0] model_bresp(int len);
        for (int i = 0; i <= len; i++)
            if (wl[i] != (i == len)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic do_write(logic [5:0] id, logic [31:0] addr, int len,
                            int size, int burst, bit stall);
        int cyc;
        int i;
        w_tmg_err = 0;
        s_awid = id; s_awaddr = addr; s_awlen = 8'(len);
        s_awsize = 3'(size); s_awburst = 2'(burst); s_awvalid = 1'b1;
        cyc = 0;
        while (s_awready !== 1'b1 && cyc < 50) begin
            @(posedge aclk); #1; cyc++;
        end
        if (s_awready !== 1'b1) w_tmg_err++;
        @(posedge aclk); #1;
        s_awvalid = 1'b0;
        i = 0; cyc = 0;
        while (i <= len && cyc < 300) begin
            s_wvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            s_wdata = wd[i]; s_wstrb = ws[i]; s_wlast = wl[i];
            if (s_wready !== 1'b1 || s_awready !== 1'b0) w_tmg_err++;
            @(posedge aclk); #1; cyc++;
            if (s_wvalid) i++;
        end
        s_wvalid = 1'b0;
        if (i <= len) w_tmg_err++;
        if (s_wready !== 1'b0 || s_bvalid !== 1'b1) w_tmg_err++;
        w_bresp = s_bresp; w_bid = s_bid;
        cyc = 0;
        while (cyc < 60) begin
            s_bready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_bvalid !== 1'b1) w_tmg_err++;
            @(posedge aclk); #1; cyc++;
            if (s_bready) break;
        end
        s_bready = 1'b0;
        if (s_bvalid !== 1'b0 || s_awready !== 1'b1) w_tmg_err++;
    endtask

    // mode: 0 never stall, 1 random stalls, 2 rready every other cycle
    task automatic do_read(logic [5:0] id, logic [31:0] addr, int len,
                           int size, int burst, int mode);
        int cyc;
        int i;
        bit held;
        logic [38:0] prev;
        r_tmg_err = 0; r_unstable = 0;
        s_arid = id; s_araddr = addr; s_arlen = 8'(len);
        s_arsize = 3'(size); s_arburst = 2'(burst); s_arvalid = 1'b1;
        cyc = 0;
        while (s_arready !== 1'b1 && cyc < 50) begin
            @(posedge aclk); #1; cyc++;
        end
        if (s_arready !== 1'b1) r_tmg_err++;
        @(posedge aclk); #1;
        s_arvalid = 1'b0;
        if (s_arready !== 1'b0) r_tmg_err++;
        i = 0; cyc = 0; held = 1'b0; prev = '0;
        while (i <= len && cyc < 300) begin
            if (mode == 0) s_rready = 1'b1;
            else if (mode == 1) s_rready = 1'($urandom_range(0, 1));
            else s_rready = 1'(cyc % 2);
            if (s_rvalid !== 1'b1) r_tmg_err++;
            if (held && {s_rdata, s_rlast, s_rid} !== prev) r_unstable++;
            prev = {s_rdata, s_rlast, s_rid};
            rd_data[i] = s_rdata; rd_last[i] = s_rlast;
            rd_id[i] = s_rid; rd_resp[i] = s_rresp;
            @(posedge aclk); #1; cyc++;
            if (s_rready) begin i++; held = 1'b0; end
            else held = 1'b1;
        end
        s_rready = 1'b0;
        if (i <= len) r_tmg_err++;
        if (s_rvalid !== 1'b0 || s_rlast !== 1'b0 || s_arready !== 1'b1)
            r_tmg_err++;
    endtask

    task automatic check_read(string nm, logic [5:0] id, logic [31:0] addr,
                              int len, int size, int burst);
        for (int k = 0; k <= len; k++) begin
            logic [31:0] exp;
            exp = ref_mem[widx(beat_addr(addr, len, size, burst, k))];
            checks++;
            if (rd_data[k] !== exp || rd_last[k] !== (k == len) ||
                rd_id[k] !== id || rd_resp[k] !== 2'b00) begin
                errors++;
                $display("FAIL %s beat %0d: got data %h last %b id %h resp %b, want %h %b %h 00",
                         nm, k, rd_data[k], rd_last[k], rd_id[k], rd_resp[k],
                         exp, (k == len), id);
            end
        end
        checks++;
        if (r_tmg_err !== 0 || r_unstable !== 0) begin
            errors++;
            $display("FAIL %s timing: got %0d timing / %0d stability faults, want 0/0",
                     nm, r_tmg_err, r_unstable);
        end
    endtask

    task automatic check_write(string nm, logic [5:0] id, int len);
        checks++;
        if (w_tmg_err !== 0 || w_bresp !== model_bresp(len) || w_bid !== id) begin
            errors++;
            $display("FAIL %s: got tmg %0d bresp %b bid %h, want 0 %b %h",
                     nm, w_tmg_err, w_bresp, w_bid, model_bresp(len), id);
        end
    endtask

    task automatic check_words(string nm, int first, int n);
        for (int k = first; k < first + n; k++) begin
            checks++;
            if (peek(k) !== ref_mem[k]) begin
                errors++;
                $display("FAIL %s word %h: got %h, want %h", nm, k, peek(k), ref_mem[k]);
            end
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast} !== 6'b0 ||
            s_bresp !== 2'b0 || s_rresp !== 2'b0 || s_bid !== 6'b0 ||
            s_rid !== 6'b0 || s_rdata !== 32'b0) begin
            errors++;
            $display("FAIL reset_values: got aw%b ar%b w%b b%b r%b l%b rdata %h, want all 0",
                     s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast, s_rdata);
        end
        areset = 1'b0;
        @(posedge aclk); #1;
        checks++;
        if (s_awready !== 1'b1 || s_arready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got awready %b arready %b, want 1 1",
                     s_awready, s_arready);
        end
    endtask

    task automatic test_single_read();
        poke(32'h10, 32'hdeaddead);
        do_read(6'h05, 32'h40, 0, 2, 1, 0);
        checks++;
        if (rd_data[0] !== 32'hdeaddead) begin
            errors++;
            $display("FAIL single_read_const: got %h, want deaddead", rd_data[0]);
        end
        check_read("single_read", 6'h05, 32'h40, 0, 2, 1);
    endtask

    task automatic test_incr_write();
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'(i + 1); ws[i] = 4'hF; wl[i] = (i == 3);
        end
        do_write(6'h2A, 32'h100, 3, 2, 1, 1'b0);
        model_write(32'h100, 3, 2, 1, 4);
        check_write("incr_write", 6'h2A, 3);
        check_words("incr_write", 32'h40, 4);
    endtask

    task automatic test_wrap_read();
        logic [31:0] want [4];
        poke(32'h40, 32'haaaa0001); poke(32'h41, 32'hbbbb0002);
        poke(32'h42, 32'hcccc0003); poke(32'h43, 32'hdddd0004);
        want[0] = 32'hcccc0003; want[1] = 32'hdddd0004;
        want[2] = 32'haaaa0001; want[3] = 32'hbbbb0002;
        do_read(6'h07, 32'h108, 3, 2, 2, 2);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd_data[k] !== want[k]) begin
                errors++;
                $display("FAIL wrap_order beat %0d: got %h, want %h", k, rd_data[k], want[k]);
            end
        end
        check_read("wrap_read", 6'h07, 32'h108, 3, 2, 2);
    endtask

    task automatic test_partial_fixed();
        poke(32'h80, 32'hffffffff);
        wd[0] = 32'h11223344; ws[0] = 4'b0101; wl[0] = 1'b1;
        do_write(6'h01, 32'h200, 0, 2, 1, 1'b0);
        model_write(32'h200, 0, 2, 1, 1);
        check_write("partial_write", 6'h01, 0);
        checks++;
        if (peek(32'h80) !== 32'hff22ff44) begin
            errors++;
            $display("FAIL partial_write_const: got %h, want ff22ff44", peek(32'h80));
        end
        for (int i = 0; i < 3; i++) begin
            wd[i] = 32'(i + 5); ws[i] = 4'hF; wl[i] = (i == 2);
        end
        do_write(6'h02, 32'h204, 2, 2, 0, 1'b1);
        model_write(32'h204, 2, 2, 0, 3);
        check_write("fixed_write", 6'h02, 2);
        checks++;
        if (peek(32'h81) !== 32'h7) begin
            errors++;
            $display("FAIL fixed_write_const: got %h, want 00000007", peek(32'h81));
        end
        check_words("fixed_write", 32'h80, 4);
    endtask

    task automatic test_wlast_err();
        wd[0] = 32'h0badf00d; ws[0] = 4'hF; wl[0] = 1'b1;
        wd[1] = 32'h600dcafe; ws[1] = 4'hF; wl[1] = 1'b0;
        do_write(6'h11, 32'h280, 1, 2, 1, 1'b0);
        model_write(32'h280, 1, 2, 1, 2);
        checks++;
        if (w_bresp !== 2'b10) begin
            errors++;
            $display("FAIL wlast_err_const: got bresp %b, want 10", w_bresp);
        end
        check_write("wlast_err", 6'h11, 1);
        check_words("wlast_err", 32'hA0, 2);
    endtask

    task automatic test_concurrent();
        for (int i = 0; i < 8; i++) begin
            wd[i] = $urandom; ws[i] = 4'hF; wl[i] = (i == 7);
        end
        fork
            do_read(6'h03, 32'h0, 7, 2, 1, 1);
            do_write(6'h09, 32'h300, 7, 2, 1, 1'b1);
        join
        model_write(32'h300, 7, 2, 1, 8);
        check_read("concurrent_read", 6'h03, 32'h0, 7, 2, 1);
        check_write("concurrent_write", 6'h09, 7);
        check_words("concurrent_write", 32'hC0, 8);
    endtask

    task automatic test_reset_mid_burst();
        int cyc;
        for (int i = 0; i < 4; i++) begin
            wd[i] = $urandom; ws[i] = 4'hF; wl[i] = (i == 3);
        end
        s_arid = 6'h04; s_araddr = 32'h20; s_arlen = 8'd7;
        s_arsize = 3'd2; s_arburst = 2'd1; s_arvalid = 1'b1;
        s_awid = 6'h06; s_awaddr = 32'h380; s_awlen = 8'd3;
        s_awsize = 3'd2; s_awburst = 2'd1; s_awvalid = 1'b1;
        cyc = 0;
        while ((s_arready !== 1'b1 || s_awready !== 1'b1) && cyc < 50) begin
            @(posedge aclk); #1; cyc++;
        end
        @(posedge aclk); #1;
        s_arvalid = 1'b0; s_awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_rready = 1'b1;
            s_wvalid = 1'b1; s_wdata = wd[k]; s_wstrb = ws[k]; s_wlast = wl[k];
            checks++;
            if (s_rvalid !== 1'b1 || s_wready !== 1'b1 ||
                s_rdata !== ref_mem[8 + k]) begin
                errors++;
                $display("FAIL mid_burst beat %0d: got rvalid %b wready %b data %h, want 1 1 %h",
                         k, s_rvalid, s_wready, s_rdata, ref_mem[8 + k]);
            end
            @(posedge aclk); #1;
        end
        model_write(32'h380, 3, 2, 1, 2);
        s_rready = 1'b0; s_wvalid = 1'b0;
        areset = 1'b1;
        @(posedge aclk); #1;
        checks++;
        if ({s_rvalid, s_rlast, s_wready, s_bvalid, s_arready, s_awready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_abort: got r%b l%b w%b b%b ar%b aw%b, want all 0",
                     s_rvalid, s_rlast, s_wready, s_bvalid, s_arready, s_awready);
        end
        areset = 1'b0;
        @(posedge aclk); #1;
        checks++;
        if (s_arready !== 1'b1 || s_awready !== 1'b1 || s_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_resume: got arready %b awready %b rvalid %b, want 1 1 0",
                     s_arready, s_awready, s_rvalid);
        end
        check_words("reset_keep", 32'hE0, 4);
        check_words("reset_keep_rd", 32'h8, 8);
        do_read(6'h08, 32'h380, 3, 2, 1, 0);
        check_read("post_reset_read", 6'h08, 32'h380, 3, 2, 1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            int len, size, burst;
            logic [31:0] addr;
            logic [5:0] id;
            burst = $urandom_range(0, 3);
            size  = $urandom_range(0, 2);
            if (burst == 2) begin
                case ($urandom_range(0, 3))
                    0: len = 1;
                    1: len = 3;
                    2: len = 7;
                    default: len = 15;
                endcase
            end else begin
                len = $urandom_range(0, 15);
            end
            addr = $urandom;
            id = 6'($urandom);
            for (int i = 0; i <= len; i++) begin
                wd[i] = $urandom;
                ws[i] = 4'($urandom);
                wl[i] = ($urandom_range(0, 7) == 0) ? (i != len) : (i == len);
            end
            do_write(id, addr, len, size, burst, 1'b1);
            model_write(addr, len, size, burst, len + 1);
            check_write("rand_write", id, len);
            do_read(~id, addr, len, size, burst, 1);
            check_read("rand_read", ~id, addr, len, size, burst);
        end
    endtask

    initial begin
        areset = 1'b1;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0;
        s_awburst = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
        s_bready = 1'b0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0;
        s_arburst = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        for (int i = 0; i < MEMW; i++) poke(i, $urandom);
        test_reset();
        test_single_read();
        test_incr_write();
        test_wrap_read();
        test_partial_fixed();
        test_wlast_err();
        test_concurrent();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
